// File: rtl/id_stage_pkg.sv
// Shared widths and RV64I opcode constants for the decode stage.
// Macro ID_STALL_CNT_EN (used by id_stage) enables the EX stall counter.
`ifndef PC_WIDTH
`define PC_WIDTH 64
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

package id_stage_pkg;

    localparam int PC_W_DEF   = `PC_WIDTH;
    localparam int INST_W_DEF = `INST_WIDTH;
    localparam int IMM_W      = 64;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;

endpackage

// File: rtl/id_imm_gen.sv
// RV64I immediate generator: instruction word to sign-extended 64-bit imm.
// Purely combinational; unknown opcodes produce zero.
module id_imm_gen
    import id_stage_pkg::*;
(
    input  logic [31:0]      inst,
    output logic [IMM_W-1:0] imm
);

    logic [6:0] opcode;
    assign opcode = inst[6:0];

    always_comb begin
        imm = '0;
        unique case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_SYSTEM:
                imm = {{52{inst[31]}}, inst[31:20]};
            OPC_STORE:
                imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                imm = {{51{inst[31]}}, inst[31], inst[7],
                       inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            OPC_JAL:
                imm = {{43{inst[31]}}, inst[31], inst[19:12],
                       inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// Decode front end: 2-entry skid buffer between IF and EX plus field decode.
// Define ID_STALL_CNT_EN to add the saturating EX stall counter output.
`ifndef PC_WIDTH
`define PC_WIDTH 64
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module id_stage
    import id_stage_pkg::*;
#(
    parameter int PC_W   = `PC_WIDTH,
    parameter int INST_W = `INST_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IF_valid_i,
    input  logic [PC_W-1:0]   IF_pc_i,
    input  logic [INST_W-1:0] IF_inst_i,
    output logic              ID_ready_o,
    input  logic              flush_i,
    output logic              ID_valid_o,
    input  logic              EX_ready_i,
    output logic [PC_W-1:0]   ID_pc_o,
    output logic [INST_W-1:0] ID_inst_o,
    output logic [4:0]        ID_rd_o,
    output logic [4:0]        ID_rs1_o,
    output logic [4:0]        ID_rs2_o,
    output logic [2:0]        ID_funct3_o,
    output logic [6:0]        ID_opcode_o,
    output logic [IMM_W-1:0]  ID_imm_o
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]       ID_stall_cnt_o
`endif
);

    logic              main_v;
    logic              skid_v;
    logic [PC_W-1:0]   main_pc;
    logic [INST_W-1:0] main_inst;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] skid_inst;
    logic              if_xfer;
    logic              main_leave;

    assign ID_ready_o = !skid_v;
    assign ID_valid_o = main_v;
    assign if_xfer    = IF_valid_i && !skid_v;
    assign main_leave = main_v && EX_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            main_pc   <= '0;
            main_inst <= '0;
            skid_pc   <= '0;
            skid_inst <= '0;
        end else if (flush_i) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (main_leave) begin
            if (skid_v) begin
                main_pc   <= skid_pc;
                main_inst <= skid_inst;
                skid_v    <= 1'b0;
            end else if (if_xfer) begin
                main_pc   <= IF_pc_i;
                main_inst <= IF_inst_i;
            end else begin
                main_v <= 1'b0;
            end
        end else if (main_v) begin
            if (if_xfer) begin
                skid_pc   <= IF_pc_i;
                skid_inst <= IF_inst_i;
                skid_v    <= 1'b1;
            end
        end else if (if_xfer) begin
            main_pc   <= IF_pc_i;
            main_inst <= IF_inst_i;
            main_v    <= 1'b1;
        end
    end

    // Decode is driven from the main register even when it is stale.
    assign ID_pc_o     = main_pc;
    assign ID_inst_o   = main_inst;
    assign ID_opcode_o = main_inst[6:0];
    assign ID_rd_o     = main_inst[11:7];
    assign ID_funct3_o = main_inst[14:12];
    assign ID_rs1_o    = main_inst[19:15];
    assign ID_rs2_o    = main_inst[24:20];

    id_imm_gen u_imm_gen (
        .inst (main_inst[31:0]),
        .imm  (ID_imm_o)
    );

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_v && !EX_ready_i && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign ID_stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Randomized and directed bench for id_stage against a queue-based model.
// Define ID_STALL_CNT_EN to also check the stall counter.
`ifndef PC_WIDTH
`define PC_WIDTH 64
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module tb_id_stage;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;
    logic        flush;
    logic        id_valid;
    logic        ex_ready;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [2:0]  id_funct3;
    logic [6:0]  id_opcode;
    logic [63:0] id_imm;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .IF_valid_i  (if_valid),
        .IF_pc_i     (if_pc),
        .IF_inst_i   (if_inst),
        .ID_ready_o  (id_ready),
        .flush_i     (flush),
        .ID_valid_o  (id_valid),
        .EX_ready_i  (ex_ready),
        .ID_pc_o     (id_pc),
        .ID_inst_o   (id_inst),
        .ID_rd_o     (id_rd),
        .ID_rs1_o    (id_rs1),
        .ID_rs2_o    (id_rs2),
        .ID_funct3_o (id_funct3),
        .ID_opcode_o (id_opcode),
        .ID_imm_o    (id_imm)
`ifdef ID_STALL_CNT_EN
        ,
        .ID_stall_cnt_o (stall_cnt)
`endif
    );

    int n_asrt = 0;
    int n_fail = 0;

    ent_t   q[$];
    ent_t   stale;
    longint cnt_m;
    bit     acc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Immediate built from the ISA field layout with signed arithmetic.
    function automatic logic [63:0] ref_imm(input logic [31:0] i);
        longint s;
        s = longint'($signed(i));
        case (i[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h73:
                return s >>> 20;
            7'h23:
                return ((s >>> 25) <<< 5) | longint'(i[11:7]);
            7'h63:
                return ((s >>> 31) <<< 12) | (longint'(i[7]) << 11)
                     | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
            7'h37, 7'h17:
                return (s >>> 12) <<< 12;
            7'h6F:
                return ((s >>> 31) <<< 20) | (longint'(i[19:12]) << 12)
                     | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
            default:
                return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        stale.pc = '0;
        stale.inst = '0;
        cnt_m = 0;
    endtask

    task automatic check_all();
        ent_t m;
        m = (q.size() > 0) ? q[0] : stale;
        chk("ready", 64'(id_ready), 64'(q.size() < 2));
        chk("valid", 64'(id_valid), 64'(q.size() > 0));
        chk("pc", id_pc, m.pc);
        chk("inst", 64'(id_inst), 64'(m.inst));
        chk("opcode", 64'(id_opcode), 64'(m.inst[6:0]));
        chk("rd", 64'(id_rd), 64'(m.inst[11:7]));
        chk("funct3", 64'(id_funct3), 64'(m.inst[14:12]));
        chk("rs1", 64'(id_rs1), 64'(m.inst[19:15]));
        chk("rs2", 64'(id_rs2), 64'(m.inst[24:20]));
        chk("imm", id_imm, ref_imm(m.inst));
`ifdef ID_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
`endif
    endtask

    task automatic tick();
        bit   rdy;
        bit   vld;
        ent_t e;
        rdy = q.size() < 2;
        vld = q.size() > 0;
        if (vld) stale = q[0];
        chk("ready_pre", 64'(id_ready), 64'(rdy));
        @(posedge clk);
        acc = if_valid && rdy && !flush;
        if (vld && !ex_ready && cnt_m != 64'hFFFF_FFFF) cnt_m++;
        if (flush) begin
            q.delete();
        end else begin
            if (vld && ex_ready) void'(q.pop_front());
            if (acc) begin
                e.pc = if_pc;
                e.inst = if_inst;
                q.push_back(e);
            end
        end
        #1;
        check_all();
    endtask

    task automatic offer(input logic [63:0] pc, input logic [31:0] inst);
        if_valid = 1'b1;
        if_pc = pc;
        if_inst = inst;
    endtask

    logic [6:0] opcs [0:10];
    logic [31:0] r_inst;

    initial begin
        opcs[0] = 7'h03; opcs[1] = 7'h13; opcs[2] = 7'h1B; opcs[3] = 7'h67;
        opcs[4] = 7'h73; opcs[5] = 7'h23; opcs[6] = 7'h63; opcs[7] = 7'h37;
        opcs[8] = 7'h17; opcs[9] = 7'h6F; opcs[10] = 7'h33;

        rst = 1'b1;
        if_valid = 1'b0;
        if_pc = '0;
        if_inst = '0;
        flush = 1'b0;
        ex_ready = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Single transfer
        offer(64'h1000, 32'h00500093);
        ex_ready = 1'b1;
        tick();
        chk("t1_valid", 64'(id_valid), 64'd1);
        chk("t1_pc", id_pc, 64'h1000);
        chk("t1_rd", 64'(id_rd), 64'd1);
        chk("t1_rs1", 64'(id_rs1), 64'd0);
        chk("t1_imm", id_imm, 64'd5);
        if_valid = 1'b0;
        tick();
        chk("t1_gone", 64'(id_valid), 64'd0);

        // Backpressure and ordered drain
        ex_ready = 1'b0;
        offer(64'h0, 32'h00100113);
        tick();
        chk("bp_acc0", 64'(acc), 64'd1);
        offer(64'h4, 32'h00200193);
        tick();
        chk("bp_acc1", 64'(acc), 64'd1);
        chk("bp_ready", 64'(id_ready), 64'd0);
        offer(64'h8, 32'h00300213);
        tick();
        chk("bp_hold", 64'(acc), 64'd0);
        chk("bp_pc0", id_pc, 64'h0);
        ex_ready = 1'b1;
        tick();
        chk("bp_pc4", id_pc, 64'h4);
        chk("bp_v4", 64'(id_valid), 64'd1);
        tick();
        chk("bp_acc2", 64'(acc), 64'd1);
        chk("bp_pc8", id_pc, 64'h8);
        chk("bp_v8", 64'(id_valid), 64'd1);
        if_valid = 1'b0;
        tick();

        // Immediate formats
        offer(64'h100, 32'hFE000EE3);
        tick();
        chk("imm_beq", id_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        offer(64'h104, 32'h123450B7);
        tick();
        chk("imm_lui", id_imm, 64'h0000_0000_1234_5000);
        offer(64'h108, 32'hFFDFF0EF);
        tick();
        chk("imm_jal", id_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        offer(64'h10C, 32'hFE112E23);
        tick();
        chk("imm_sw", id_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        if_valid = 1'b0;
        tick();

        // Flush with both entries full and a concurrent offer
        ex_ready = 1'b0;
        offer(64'h200, 32'h00000013);
        tick();
        offer(64'h204, 32'h00000013);
        tick();
        chk("fl_full", 64'(id_ready), 64'd0);
        offer(64'h208, 32'h00000013);
        flush = 1'b1;
        tick();
        chk("fl_valid", 64'(id_valid), 64'd0);
        chk("fl_ready", 64'(id_ready), 64'd1);
        flush = 1'b0;
        if_valid = 1'b0;
        tick();
        chk("fl_dropped", 64'(id_valid), 64'd0);

        // Asynchronous reset between edges
        offer(64'h300, 32'h00000013);
        tick();
        offer(64'h304, 32'h00000013);
        tick();
        if_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(id_valid), 64'd0);
        chk("ar_ready", 64'(id_ready), 64'd1);
        chk("ar_pc", id_pc, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();

`ifdef ID_STALL_CNT_EN
        ex_ready = 1'b0;
        offer(64'h400, 32'h00000013);
        tick();
        if_valid = 1'b0;
        repeat (7) tick();
        chk("sc_seven", 64'(stall_cnt), 64'd7);
        ex_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sc_flush", 64'(stall_cnt), 64'd7);
`endif

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            r_inst = $urandom();
            if ($urandom_range(0, 1) == 0)
                r_inst[6:0] = opcs[$urandom_range(0, 10)];
            if_valid = ($urandom_range(0, 2) != 0);
            if_pc = {32'($urandom()), 32'($urandom())};
            if_inst = r_inst;
            ex_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        if_valid = 1'b0;
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode-stage front end: the receiving end of the IF→ID valid/ready handshake.
- Accepts {pc, instruction} from fetch into a 2-entry skid buffer and presents one held entry to EX with its own valid/ready handshake.
- Decodes RV64I register fields and the sign-extended immediate from the held entry.
- Supports a pipeline flush from the back end.

Parameters:
- PC_W, `PC_WIDTH (64), pc width
- INST_W, 32, instruction width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- IF_valid_i  in  1  fetch offers pc/inst
- IF_pc_i  in  PC_W  fetch pc
- IF_inst_i  in  INST_W  fetched instruction
- ID_ready_o  out  1  ID can accept a transfer this cycle
- flush_i  in  1  discard all held entries
- ID_valid_o  out  1  held entry valid toward EX
- EX_ready_i  in  1  EX accepts the held entry
- ID_pc_o  out  PC_W  pc of held entry
- ID_inst_o  out  INST_W  instruction of held entry
- ID_rd_o / ID_rs1_o / ID_rs2_o  out  5 each  inst[11:7] / [19:15] / [24:20]
- ID_funct3_o  out  3  inst[14:12]
- ID_opcode_o  out  7  inst[6:0]
- ID_imm_o  out  64  sign-extended immediate

Behaviour:
- Reset (async, rst=1): main_v=0, skid_v=0, all data registers 0. Outputs during reset: ID_valid_o=0, ID_ready_o=1, ID_pc_o=0, ID_inst_o=0, all decode outputs 0.
- ID_ready_o = !skid_v. It is registered-derived and never depends combinationally on IF_valid_i or EX_ready_i.
- Transfers:
  - IF transfer: IF_valid_i && ID_ready_o at a rising edge.
  - EX transfer: ID_valid_o && EX_ready_i at a rising edge.
- ID_valid_o = main_v. ID_pc_o, ID_inst_o and the decode outputs are driven from the main entry.
- Latency: an IF transfer at edge t with main empty (or main leaving) gives ID_valid_o=1 with that data after edge t.
- Per-edge update, when no flush:
  - Main leaving, skid_v=1: main ← skid, skid_v ← 0. An IF transfer is impossible in this case (ready=0).
  - Main leaving, no skid, IF transfer: main ← input, main_v=1.
  - Main leaving, no skid, no IF transfer: main_v ← 0.
  - Main not leaving, main_v=1, IF transfer: skid ← input, skid_v=1.
  - main_v=0, IF transfer: main ← input.
- Order is strictly preserved. There is no loss and no duplication.
- flush_i=1 at an edge: main_v=0, skid_v=0. A concurrent IF transfer is dropped; flush wins over every other event.
  - EX must ignore ID_valid_o in a flush cycle. EX is the flush source.
- Decode, combinational from main_inst, opcode = inst[6:0]:
  - I-type (0000011, 0010011, 0011011, 1100111, 1110011): sext(inst[31:20])
  - S-type (0100011): sext({inst[31:25], inst[11:7]})
  - B-type (1100011): sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
  - U-type (0110111, 0010111): sext({inst[31:12], 12'b0})
  - J-type (1101111): sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})
  - Any other opcode: imm = 0
- Field outputs are raw slices, valid regardless of instruction format. When main_v=0, all decode outputs are still driven from the (stale) main register; consumers qualify them with ID_valid_o.
- Reset asserted mid-transfer: immediate clear, as at reset; no partial state survives.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- Defined:
  - Adds output ID_stall_cnt_o (32 bits).
  - Counts edges where ID_valid_o && !EX_ready_i.
  - Saturates at 0xFFFF_FFFF.
  - Reset to 0 by rst only; unaffected by flush.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared defines: `PC_WIDTH, `INST_WIDTH; opcode constants OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL.
- One sub-module: id_imm_gen (combinational, inst → 64-bit imm), reused by later stages.
- The skid buffer stays inline.

Test Plan:
- Reset, then a single transfer: IF_valid_i=1, pc=0x1000, inst=0x00500093 (addi x1,x0,5), EX_ready_i=1 → next cycle ID_valid_o=1, ID_pc_o=0x1000, rd=1, rs1=0, imm=5. The following cycle ID_valid_o=0.
- Backpressure: EX_ready_i=0, three consecutive offers pc=0x0, 0x4, 0x8 → first two accepted, ID_ready_o=0 after the second, third held by IF. Raise EX_ready_i → outputs pc 0x0, 0x4, 0x8 in order, no gaps after the release.
- Immediates:
  - inst=0xFE000EE3 (beq, offset −4) → imm=0xFFFF_FFFF_FFFF_FFFC
  - 0x123450B7 (lui) → imm=0x0000_0000_1234_5000
  - 0xFFDFF0EF (jal, −4) → imm=0xFFFF_FFFF_FFFF_FFFC
  - 0xFE112E23 (sw, −4) → imm=0xFFFF_FFFF_FFFF_FFFC
- Flush with both entries full and concurrent IF_valid_i=1 → next cycle ID_valid_o=0, ID_ready_o=1, the offered entry is not captured.
- Async reset asserted between edges while both entries are full → ID_valid_o=0 and ID_ready_o=1 immediately, without waiting for an edge.
- With ID_STALL_CNT_EN: hold ID_valid_o=1 with EX_ready_i=0 for 7 cycles → ID_stall_cnt_o=7. Apply a flush → still 7.
